// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the FSM state encoding, the 4x4 hex legend and bit-count helpers.
// Helpers take a fixed 32-bit vector; callers zero-extend narrower rows.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Width of the vectors accepted by the helper functions below.
  localparam int FN_W = 32;

  // Hex legend of the standard 4x4 pad, indexed [col_idx][row_idx].
  localparam logic [3:0] LEGEND [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Number of set bits.
  function automatic logic [5:0] popcount(input logic [FN_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < FN_W; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit otherwise).
  function automatic logic [4:0] onehot_index(input logic [FN_W-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < FN_W; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Column dwell timer: one-cycle tick every SCAN_DIV clocks, on the last dwell cycle.
// Tick is a decode of the registered counter, so it is valid in the same cycle.
// Free-running; restarts from zero whenever reset is asserted.
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap the dwell counter after its last cycle.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Dwell counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad front end: one-hot column drive, debounced single-key decode.
// num/key_valid/key_held update one cycle after the accepting tick.
// Rejects multi-row samples as ghosts; no auto-repeat while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_CNT   = 4,
  parameter int LEGEND_EN = 1,
  parameter int KEY_W     = 4
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  fil,
  output logic [COLS-1:0]  col,
  output logic [KEY_W-1:0] num,
  output logic             key_valid,
  output logic             key_held,
  output logic             ghost_err
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CNT - 1);

  // Key code: hex legend, or plain linear index when the legend is disabled.
  function automatic logic [KEY_W-1:0] key_code(input logic [CW-1:0] c,
                                                input logic [RW-1:0] r);
    logic [1:0] c2;
    logic [1:0] r2;
    c2 = 2'(c);
    r2 = 2'(r);
    if (LEGEND_EN != 0) return KEY_W'(LEGEND[c2][r2]);
    else                return KEY_W'(int'(c) * ROWS + int'(r));
  endfunction

  logic             tick;
  logic [ROWS-1:0]  fil_s1_q;
  logic [ROWS-1:0]  fil_s2_q;

  state_e           state_q;
  logic [COLS-1:0]  col_q;
  logic [CW-1:0]    col_idx_q;
  logic [CW-1:0]    cand_col_q;
  logic [RW-1:0]    cand_row_q;
  logic [DW-1:0]    deb_cnt_q;
  logic [DW-1:0]    rel_cnt_q;
  logic [KEY_W-1:0] num_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic             ghost_err_q;

  logic [5:0]       samp_ones;
  logic             samp_zero;
  logic             samp_single;
  logic             samp_multi;
  logic [RW-1:0]    samp_row;
  logic             match_row;
  logic [CW-1:0]    col_idx_nxt;
  logic [COLS-1:0]  col_nxt;
  logic [KEY_W-1:0] scan_code;
  logic [KEY_W-1:0] cand_code;

  scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_i (clk1),
    .rst_ni(rst_n),
    .tick_o(tick)
  );

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fil_s1_q <= '0;
      fil_s2_q <= '0;
    end else begin
      fil_s1_q <= fil;
      fil_s2_q <= fil_s1_q;
    end
  end

  // Classify the synchronised sample and precompute next column and codes.
  always_comb begin
    samp_ones   = popcount(FN_W'(fil_s2_q));
    samp_zero   = (samp_ones == 6'd0);
    samp_single = (samp_ones == 6'd1);
    samp_multi  = (samp_ones > 6'd1);
    samp_row    = RW'(onehot_index(FN_W'(fil_s2_q)));
    match_row   = samp_single && (samp_row == cand_row_q);
    col_idx_nxt = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + CW'(1);
    col_nxt     = COLS'(1) << col_idx_nxt;
    scan_code   = key_code(col_idx_q, samp_row);
    cand_code   = key_code(cand_col_q, cand_row_q);
  end

  // Scan / debounce / held state machine; all outputs are registered here.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_q       <= COLS'(1);
      col_idx_q   <= '0;
      cand_col_q  <= '0;
      cand_row_q  <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      num_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      ghost_err_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      ghost_err_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (samp_single) begin
              cand_col_q <= col_idx_q;
              cand_row_q <= samp_row;
              if (DEB_CNT == 1) begin
                // Single-sample debounce: accept on the detecting tick.
                num_q       <= scan_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                deb_cnt_q   <= '0;
                rel_cnt_q   <= '0;
                state_q     <= HELD;
              end else begin
                deb_cnt_q <= DW'(1);
                state_q   <= DEBOUNCE;
              end
            end else begin
              // Empty or ghosted column: move on.
              ghost_err_q <= samp_multi;
              col_idx_q   <= col_idx_nxt;
              col_q       <= col_nxt;
            end
          end
          DEBOUNCE: begin
            if (match_row) begin
              if (deb_cnt_q == CNT_LAST) begin
                num_q       <= cand_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                deb_cnt_q   <= '0;
                rel_cnt_q   <= '0;
                state_q     <= HELD;
              end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
              end
            end else begin
              // Bounce or pattern change: abandon the candidate.
              ghost_err_q <= samp_multi;
              deb_cnt_q   <= '0;
              state_q     <= SCAN;
              col_idx_q   <= col_idx_nxt;
              col_q       <= col_nxt;
            end
          end
          HELD: begin
            if (samp_zero) begin
              if (rel_cnt_q == CNT_LAST) begin
                rel_cnt_q  <= '0;
                key_held_q <= 1'b0;
                state_q    <= SCAN;
                col_idx_q  <= col_idx_nxt;
                col_q      <= col_nxt;
              end else begin
                rel_cnt_q <= rel_cnt_q + DW'(1);
              end
            end else begin
              rel_cnt_q <= '0;
            end
          end
          default: begin
            state_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign num       = num_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign ghost_err = ghost_err_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a tick-level reference model.
// Keys are changed only just after a tick edge so the synchroniser has settled
// by the next sample; the model then sees the same rows the design samples.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB_CNT  = 2;
  localparam int KEY_W    = 4;

  logic             clk1;
  logic             rst_n;
  logic [ROWS-1:0]  fil;
  logic [COLS-1:0]  col;
  logic [KEY_W-1:0] num;
  logic             key_valid;
  logic             key_held;
  logic             ghost_err;

  // Physical key matrix: rows closed in each column.
  logic [3:0] keys [4];

  int checks = 0;
  int errors = 0;

  // Reference model state (tick level, integer key indices).
  int legend_tb [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int m_col, m_num, m_cand, m_agree, m_zeros;
  bit m_valid, m_held, m_ghost;
  int edge_n;
  int detect_edge, valid_edge;
  int vcount, gcount;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEB_CNT(DEB_CNT), .LEGEND_EN(1), .KEY_W(KEY_W)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .fil(fil), .col(col), .num(num),
    .key_valid(key_valid), .key_held(key_held), .ghost_err(ghost_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Keypad: the driven column connects its closed keys to the row lines.
  always_comb begin
    fil = '0;
    for (int c = 0; c < 4; c++) begin
      if (col[c]) fil = fil | keys[c];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_num = 0; m_cand = -1; m_agree = 0; m_zeros = 0;
    m_valid = 0; m_held = 0; m_ghost = 0; edge_n = 0;
  endtask

  task automatic model_accept();
    m_num   = legend_tb[m_cand];
    m_valid = 1;
    m_held  = 1;
    m_cand  = -1;
    m_zeros = 0;
  endtask

  // One clock edge of the reference: sample the active column every SCAN_DIV edges.
  task automatic model_edge();
    logic [3:0] r;
    int n;
    int row;
    m_valid = 0;
    m_ghost = 0;
    edge_n++;
    if (edge_n % SCAN_DIV != 0) return;
    r = keys[m_col];
    n = $countones(r);
    row = 0;
    for (int i = 0; i < 4; i++) if (r[i]) row = i;
    if (m_held) begin
      if (n == 0) begin
        m_zeros++;
        if (m_zeros == DEB_CNT) begin
          m_held = 0; m_zeros = 0; m_col = (m_col + 1) % COLS;
        end
      end else begin
        m_zeros = 0;
      end
    end else if (m_cand < 0) begin
      if (n == 1) begin
        m_cand = m_col * 4 + row;
        m_agree = 1;
        detect_edge = edge_n;
        if (m_agree == DEB_CNT) model_accept();
      end else begin
        if (n > 1) m_ghost = 1;
        m_col = (m_col + 1) % COLS;
      end
    end else begin
      if (n == 1 && m_col * 4 + row == m_cand) begin
        m_agree++;
        if (m_agree == DEB_CNT) model_accept();
      end else begin
        if (n > 1) m_ghost = 1;
        m_cand = -1;
        m_col = (m_col + 1) % COLS;
      end
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic step();
    @(posedge clk1);
    model_edge();
    @(negedge clk1);
    chk("col", 32'(col), 32'(1 << m_col));
    chk("num", 32'(num), 32'(m_num));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("ghost_err", 32'(ghost_err), 32'(m_ghost));
    if (key_valid === 1'b1) begin
      vcount++;
      valid_edge = edge_n;
    end
    if (ghost_err === 1'b1) gcount++;
  endtask

  task automatic run_ticks(input int k);
    for (int i = 0; i < k * SCAN_DIV; i++) step();
  endtask

  task automatic wait_col(input int c);
    for (int i = 0; i < 8 && m_col != c; i++) run_ticks(1);
    chk("wait_col", 32'(col), 32'(1 << c));
  endtask

  task automatic clear_keys();
    for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"}, 32'(col), 32'h1);
    chk({tag, "_num"}, 32'(num), 32'h0);
    chk({tag, "_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_held"}, 32'(key_held), 32'h0);
    chk({tag, "_ghost"}, 32'(ghost_err), 32'h0);
  endtask

  initial begin
    int kc, kr, r2, pick;
    clear_keys();
    vcount = 0; gcount = 0; detect_edge = 0; valid_edge = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk1);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: idle scan walks the columns, no key reported.
    run_ticks(4);
    chk("idle_valid_count", 32'(vcount), 32'd0);

    // 2: key 6 (column 1, row 2) held; column freezes, latency from detect tick.
    keys[1] = 4'b0100;
    run_ticks(4);
    chk("press6_num", 32'(num), 32'h6);
    chk("press6_col_frozen", 32'(col), 32'b0010);
    chk("press6_held", 32'(key_held), 32'h1);
    chk("press6_valid_count", 32'(vcount), 32'd1);
    chk("press6_latency", 32'(valid_edge - detect_edge + 1),
        32'((DEB_CNT - 1) * SCAN_DIV + 1));
    clear_keys();
    run_ticks(2);
    chk("release6_held", 32'(key_held), 32'h0);

    // 3: one-tick bounce on column 3 is dropped and the scan resumes at column 0.
    wait_col(3);
    keys[3] = 4'b0001;
    run_ticks(1);
    clear_keys();
    run_ticks(1);
    chk("bounce_col", 32'(col), 32'b0001);
    chk("bounce_num", 32'(num), 32'h6);
    chk("bounce_valid_count", 32'(vcount), 32'd1);

    // 4: two rows in column 0 flag a ghost and the column advances.
    keys[0] = 4'b1010;
    run_ticks(1);
    clear_keys();
    chk("ghost_count", 32'(gcount), 32'd1);
    chk("ghost_col", 32'(col), 32'b0010);
    chk("ghost_valid_count", 32'(vcount), 32'd1);

    // 5: press 0, release, press A.
    wait_col(3);
    keys[3] = 4'b0010;
    run_ticks(2);
    chk("press0_num", 32'(num), 32'h0);
    chk("press0_held", 32'(key_held), 32'h1);
    clear_keys();
    run_ticks(2);
    chk("release0_held", 32'(key_held), 32'h0);
    wait_col(0);
    keys[0] = 4'b1000;
    run_ticks(2);
    chk("pressA_num", 32'(num), 32'hA);
    chk("pressA_valid_count", 32'(vcount), 32'd3);

    // 6: one-cycle reset while A is held; everything clears, then A is re-reported.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk1);
    rst_n = 1'b1;
    vcount = 0;
    run_ticks(3);
    chk("rereport_num", 32'(num), 32'hA);
    chk("rereport_valid_count", 32'(vcount), 32'd1);
    clear_keys();
    run_ticks(2);

    // Random key activity against the model.
    for (int s = 0; s < 60; s++) begin
      clear_keys();
      pick = $urandom_range(0, 5);
      kc = $urandom_range(0, 3);
      kr = $urandom_range(0, 3);
      case (pick)
        1, 2: keys[kc][kr] = 1'b1;
        3: begin
          r2 = (kr + 1 + $urandom_range(0, 2)) % 4;
          keys[kc][kr] = 1'b1;
          keys[kc][r2] = 1'b1;
        end
        4: begin
          keys[kc][kr] = 1'b1;
          keys[(kc + 1) % 4][$urandom_range(0, 3)] = 1'b1;
        end
        default: ;
      endcase
      run_ticks($urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
